// File: rtl/vote_pkg.sv
// Shared voting definitions: candidate count, vote index width, conditioner
// state encoding and one-hot/index helpers.
package vote_pkg;

    localparam int unsigned NUM_CAND  = 4;
    localparam int unsigned VOTE_ID_W = $clog2(NUM_CAND);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEBOUNCE    = 3'd1,
        HOLD        = 3'd2,
        REJECT_WAIT = 3'd3,
        LOCKOUT     = 3'd4
    } vote_state_t;

    // Index of the highest set bit; callers only pass one-hot vectors.
    function automatic logic [VOTE_ID_W-1:0] onehot_to_idx(input logic [NUM_CAND-1:0] vec);
        logic [VOTE_ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vec[i]) begin
                idx = VOTE_ID_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [NUM_CAND-1:0] idx_to_onehot(input logic [VOTE_ID_W-1:0] idx);
        return NUM_CAND'(1) << idx;
    endfunction

endpackage

// File: rtl/vote_sync2.sv
// Per-bit two-flop synchronizer for raw asynchronous inputs.
module vote_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vote_input_conditioner.sv
// Debounces four candidate buttons into single vote pulses, discarding
// multi-button presses. Define VOTE_LOCKOUT_EN to add post-vote dead time.
module vote_input_conditioner
    import vote_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LOCKOUT_CYCLES  = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mode,
    input  logic                 button1,
    input  logic                 button2,
    input  logic                 button3,
    input  logic                 button4,
    output logic                 vote_valid,
    output logic [VOTE_ID_W-1:0] vote_id,
    output logic                 reject,
    output logic                 busy
);

    localparam int unsigned MAX_CYC = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES
                                                                         : LOCKOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef VOTE_LOCKOUT_EN
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
`endif

    logic [NUM_CAND-1:0]  raw;
    logic [NUM_CAND-1:0]  synced;
    logic                 any_high;
    logic                 one_high;
    logic                 multi_high;
    logic                 match;

    vote_state_t          state;
    vote_state_t          state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [VOTE_ID_W-1:0] cap_id;
    logic [VOTE_ID_W-1:0] cap_id_nxt;

    logic                 vote_valid_nxt;
    logic [VOTE_ID_W-1:0] vote_id_nxt;
    logic                 reject_nxt;
    logic                 busy_nxt;

    assign raw = {button4, button3, button2, button1};

    vote_sync2 #(
        .WIDTH (NUM_CAND)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (raw),
        .q     (synced)
    );

    assign any_high   = |synced;
    assign one_high   = $onehot(synced);
    assign multi_high = any_high && !one_high;
    assign match      = (synced == idx_to_onehot(cap_id));

    // State, counter, captured candidate and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_id     <= '0;
            vote_valid <= 1'b0;
            vote_id    <= '0;
            reject     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cap_id     <= cap_id_nxt;
            vote_valid <= vote_valid_nxt;
            vote_id    <= vote_id_nxt;
            reject     <= reject_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next state; display mode overrides every state
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cap_id_nxt = cap_id;
        if (mode) begin
            state_nxt = any_high ? REJECT_WAIT : IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (one_high) begin
                        state_nxt  = DEBOUNCE;
                        cap_id_nxt = onehot_to_idx(synced);
                        cnt_nxt    = '0;
                    end else if (multi_high) begin
                        state_nxt = REJECT_WAIT;
                    end
                end
                DEBOUNCE: begin
                    if (match) begin
                        if (cnt == DEB_LAST) begin
                            state_nxt = HOLD;
                        end else if (cnt != CNT_SAT) begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end else if (!any_high) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = REJECT_WAIT;
                    end
                end
                HOLD: begin
                    if (!any_high) begin
`ifdef VOTE_LOCKOUT_EN
                        state_nxt = LOCKOUT;
                        cnt_nxt   = '0;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
                REJECT_WAIT: begin
                    if (!any_high) begin
                        state_nxt = IDLE;
                    end
                end
`ifdef VOTE_LOCKOUT_EN
                LOCKOUT: begin
                    if (cnt == LOCK_LAST) begin
                        state_nxt = IDLE;
                    end else if (cnt != CNT_SAT) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output pulses are decided from the same cycle's conditions, then registered
    always_comb begin
        vote_valid_nxt = 1'b0;
        vote_id_nxt    = '0;
        reject_nxt     = 1'b0;
        busy_nxt       = (state_nxt != IDLE);
        if (!mode) begin
            if (state == DEBOUNCE && match && cnt == DEB_LAST) begin
                vote_valid_nxt = 1'b1;
                vote_id_nxt    = cap_id;
            end
            if ((state == IDLE && multi_high) ||
                (state == DEBOUNCE && !match && any_high)) begin
                reject_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Self-checking bench: directed segment table, reset corner case and random
// stimulus against an event-level behavioural model.
module tb_vote_input_conditioner;

    localparam int D = 4;
    localparam int L = 10;
`ifdef VOTE_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       mode;
    logic       button1, button2, button3, button4;
    logic       vote_valid;
    logic [1:0] vote_id;
    logic       reject;
    logic       busy;

    int total;
    int bad;

    vote_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LOCKOUT_CYCLES  (L)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .button1    (button1),
        .button2    (button2),
        .button3    (button3),
        .button4    (button4),
        .vote_valid (vote_valid),
        .vote_id    (vote_id),
        .reject     (reject),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: raw inputs reach the logic two edges late; the phase
    // is tracked as a debounce run length, a wait-for-release flag and a
    // remaining dead-time count.
    logic [3:0] hist[$];
    int         m_stable;
    int         m_who;
    bit         m_wait;
    bit         m_voted;
    int         m_dead;
    bit         e_valid;
    int         e_id;
    bit         e_rej;
    bit         e_busy;

    task automatic model_reset();
        hist     = {4'b0000, 4'b0000};
        m_stable = -1;
        m_who    = 0;
        m_wait   = 1'b0;
        m_voted  = 1'b0;
        m_dead   = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw_btn, input logic m);
        logic [3:0] s;
        s = hist.pop_front();
        hist.push_back(raw_btn);
        e_valid = 1'b0;
        e_rej   = 1'b0;
        e_id    = 0;
        if (m) begin
            m_stable = -1;
            m_dead   = 0;
            m_voted  = 1'b0;
            m_wait   = (s != 4'b0000);
        end else if (m_dead > 0) begin
            m_dead = m_dead - 1;
        end else if (m_wait) begin
            if (s == 4'b0000) begin
                m_wait = 1'b0;
                if (m_voted && LOCK_EN) m_dead = L;
                m_voted = 1'b0;
            end
        end else if (m_stable >= 0) begin
            if (s == 4'(1 << m_who)) begin
                if (m_stable == D - 1) begin
                    e_valid  = 1'b1;
                    e_id     = m_who;
                    m_stable = -1;
                    m_wait   = 1'b1;
                    m_voted  = 1'b1;
                end else begin
                    m_stable = m_stable + 1;
                end
            end else if (s == 4'b0000) begin
                m_stable = -1;
            end else begin
                e_rej    = 1'b1;
                m_stable = -1;
                m_wait   = 1'b1;
                m_voted  = 1'b0;
            end
        end else if ($countones(s) == 1) begin
            m_stable = 0;
            for (int i = 0; i < 4; i++) begin
                if (s[i]) m_who = i;
            end
        end else if (s != 4'b0000) begin
            e_rej   = 1'b1;
            m_wait  = 1'b1;
            m_voted = 1'b0;
        end
        e_busy = (m_stable >= 0) || m_wait || (m_dead > 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, compare against the model
    task automatic step(input logic [3:0] btn, input logic m);
        {button4, button3, button2, button1} = btn;
        mode = m;
        @(posedge clock);
        #1;
        model_edge(btn, m);
        chk("vote_valid", int'(vote_valid), int'(e_valid));
        chk("reject", int'(reject), int'(e_rej));
        chk("busy", int'(busy), int'(e_busy));
        if (e_valid) chk("vote_id", int'(vote_id), e_id);
    endtask

    typedef struct {
        logic [3:0] btn;
        logic       md;
        int         cycles;
        int         votes;
        int         vote_at;
        int         id;
        int         rejects;
        int         rej_at;
        logic       busy_end;
    } seg_t;

    seg_t seg_q[$];

    task automatic add(input logic [3:0] btn, input logic md, input int cycles,
                       input int votes, input int vote_at, input int id,
                       input int rejects, input int rej_at, input logic busy_end);
        seg_t sg;
        sg = '{btn, md, cycles, votes, vote_at, id, rejects, rej_at, busy_end};
        seg_q.push_back(sg);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_vote_valid"}, int'(vote_valid), 0);
        chk({tag, "_vote_id"}, int'(vote_id), 0);
        chk({tag, "_reject"}, int'(reject), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int         nv, nr, va, vid, ra;
        int         r, len;
        logic [3:0] pat;
        logic       md;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        mode  = 1'b0;
        {button4, button3, button2, button1} = 4'b0000;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        outputs_zero("reset_state");
        reset = 1'b0;

        // btn, mode, cycles, votes, vote_at, id, rejects, rej_at, busy_end
        add(4'b0000, 1'b0,  5, 0, 0, 0, 0, 0, 1'b0);
        add(4'b0001, 1'b0, 20, 1, 7, 0, 0, 0, 1'b1);
        add(4'b0000, 1'b0, 16, 0, 0, 0, 0, 0, 1'b0);
        add(4'b0100, 1'b0,  2, 0, 0, 0, 0, 0, 1'b0);
        add(4'b0000, 1'b0,  8, 0, 0, 0, 0, 0, 1'b0);
        add(4'b0110, 1'b0, 20, 0, 0, 0, 1, 3, 1'b1);
        add(4'b0000, 1'b0,  6, 0, 0, 0, 0, 0, 1'b0);
        add(4'b0100, 1'b0, 10, 1, 7, 2, 0, 0, 1'b1);
        add(4'b0000, 1'b0, 16, 0, 0, 0, 0, 0, 1'b0);
        add(4'b0010, 1'b1, 20, 0, 0, 0, 0, 0, 1'b1);
        add(4'b0000, 1'b0,  6, 0, 0, 0, 0, 0, 1'b0);
        add(4'b1000, 1'b0, 12, 1, 7, 3, 0, 0, 1'b1);
        add(4'b0000, 1'b0, 16, 0, 0, 0, 0, 0, 1'b0);
        add(4'b0001, 1'b0,  8, 1, 7, 0, 0, 0, 1'b1);
        add(4'b0000, 1'b0,  2, 0, 0, 0, 0, 0, 1'b1);
        add(4'b0010, 1'b0, 10, LOCK_EN ? 0 : 1, LOCK_EN ? 0 : 7, 1, 0, 0, 1'b1);
        add(4'b0000, 1'b0, 10, 0, 0, 0, 0, 0, 1'b0);
        add(4'b0010, 1'b0, 10, 1, 7, 1, 0, 0, 1'b1);
        add(4'b0000, 1'b0, 16, 0, 0, 0, 0, 0, 1'b0);
        add(4'b0001, 1'b0,  4, 0, 0, 0, 0, 0, 1'b1);
        add(4'b0011, 1'b0, 10, 0, 0, 0, 1, 3, 1'b1);
        add(4'b0000, 1'b0,  6, 0, 0, 0, 0, 0, 1'b0);
        add(4'b1000, 1'b0,  5, 0, 0, 0, 0, 0, 1'b1);
        add(4'b1000, 1'b1,  4, 0, 0, 0, 0, 0, 1'b1);
        add(4'b0000, 1'b0,  6, 0, 0, 0, 0, 0, 1'b0);

        foreach (seg_q[i]) begin
            nv = 0; nr = 0; va = 0; vid = 0; ra = 0;
            for (int c = 1; c <= seg_q[i].cycles; c++) begin
                step(seg_q[i].btn, seg_q[i].md);
                if (vote_valid) begin
                    nv++;
                    if (va == 0) begin
                        va  = c;
                        vid = int'(vote_id);
                    end
                end
                if (reject) begin
                    nr++;
                    if (ra == 0) ra = c;
                end
            end
            chk($sformatf("seg%0d_votes", i), nv, seg_q[i].votes);
            chk($sformatf("seg%0d_vote_at", i), va, seg_q[i].vote_at);
            if (seg_q[i].votes > 0) chk($sformatf("seg%0d_vote_id", i), vid, seg_q[i].id);
            chk($sformatf("seg%0d_rejects", i), nr, seg_q[i].rejects);
            chk($sformatf("seg%0d_rej_at", i), ra, seg_q[i].rej_at);
            chk($sformatf("seg%0d_busy_end", i), int'(busy), int'(seg_q[i].busy_end));
        end

        // Reset two cycles into DEBOUNCE with button1 held throughout
        repeat (5) step(4'b0001, 1'b0);
        reset = 1'b1;
        #1;
        outputs_zero("async_reset");
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            outputs_zero("in_reset");
        end
        reset = 1'b0;
        model_reset();
        nv = 0; va = 0; vid = 0;
        for (int c = 1; c <= 14; c++) begin
            step(4'b0001, 1'b0);
            if (vote_valid) begin
                nv++;
                if (va == 0) begin
                    va  = c;
                    vid = int'(vote_id);
                end
            end
        end
        chk("post_reset_votes", nv, 1);
        chk("post_reset_vote_at", va, 7);
        chk("post_reset_vote_id", vid, 0);
        repeat (16) step(4'b0000, 1'b0);

        // Randomised held patterns, mostly single presses
        for (int blk = 0; blk < 400; blk++) begin
            r = $urandom_range(0, 9);
            if (r < 3) pat = 4'b0000;
            else if (r < 8) pat = 4'b0001 << $urandom_range(0, 3);
            else pat = 4'($urandom_range(1, 15));
            md  = ($urandom_range(0, 15) == 0);
            len = $urandom_range(1, 14);
            for (int c = 0; c < len; c++) step(pat, md);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vote_input_conditioner.md
VOTE_INPUT_CONDITIONER -- requirements
Module: vote_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required to accept a press (legal range 2..255).
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 64: post-vote dead time in cycles (legal range 1..65535; used only when VOTE_LOCKOUT_EN is defined).
REQ-003 SHALL have port clock, input, 1: single clock; all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port mode, input, 1: 0 = voting, 1 = result display; votes are suppressed while 1.
REQ-006 SHALL have ports button1..button4, input, 1 each: raw asynchronous candidate buttons.
REQ-007 SHALL have port vote_valid, output, 1: one-cycle pulse marking an accepted vote.
REQ-008 SHALL have port vote_id, output, 2: candidate index 0..3 (button1..button4), valid only with vote_valid.
REQ-009 SHALL have port reject, output, 1: one-cycle pulse when a multi-button press is discarded.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-012 SHALL implement FSM states IDLE, DEBOUNCE, HOLD, REJECT_WAIT, LOCKOUT.
REQ-013 IDLE: exactly one synced button high and mode=0 -> DEBOUNCE, capture index, counter cleared; two or more high -> REJECT_WAIT with reject pulsed once.
REQ-014 DEBOUNCE: counter increments while the synced vector equals the captured one-hot; all buttons low -> IDLE with no output; any other change -> REJECT_WAIT with reject pulsed.
REQ-015 SHALL pulse vote_valid with vote_id equal to the captured index in the cycle the counter reaches DEBOUNCE_CYCLES-1, then enter HOLD; latency from the first clock edge sampling the raw press = 2 + DEBOUNCE_CYCLES cycles.
REQ-016 HOLD: no further votes until all synced buttons are low for one cycle; a press held indefinitely SHALL yield exactly one vote.
REQ-017 HOLD: an additional button going high SHALL be ignored (the vote is already counted, no reject).
REQ-018 REJECT_WAIT: SHALL wait for all synced buttons low, then -> IDLE; no vote is emitted.
REQ-019 mode=1 in any state SHALL force IDLE on the next edge if all buttons are low, otherwise REJECT_WAIT without a reject pulse; vote_valid SHALL never assert while mode=1.
REQ-020 vote_valid and reject SHALL never assert in the same cycle, and neither SHALL exceed one cycle per event.
REQ-021 Counter width SHALL be ceil(log2(max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES)+1)) and SHALL saturate, never wrap.

Reset
REQ-022 Reset SHALL asynchronously force state IDLE, synchronizer flops 0, counter 0, vote_valid 0, vote_id 0, reject 0, busy 0.
REQ-023 Reset mid-DEBOUNCE or mid-LOCKOUT SHALL discard the pending vote; after release, a still-held button SHALL be treated as a new press.

Configuration
REQ-024 With VOTE_LOCKOUT_EN defined, HOLD exit on release SHALL enter LOCKOUT for LOCKOUT_CYCLES cycles, ignoring all buttons, then -> IDLE; without it, HOLD exit SHALL go directly to IDLE and LOCKOUT logic SHALL be absent.

Structure
REQ-025 State encoding typedef, candidate-count constant (4) and vote_id width SHALL reside in shared package vote_pkg, which the voting-machine counter stage also imports.
REQ-026 The synchronizer SHALL be the sub-module vote_sync2 (per-bit 2-flop, width parameter); all other logic stays in this module.

Verification
REQ-027 DEBOUNCE_CYCLES=4: button1 held 20 cycles -> exactly one vote_valid, vote_id=0, 6 cycles after the press.
REQ-028 button3 pulsed for 2 cycles, then low -> no vote_valid, no reject, busy returns to 0.
REQ-029 button2 and button3 asserted together for 20 cycles -> one reject pulse, zero votes; after release, button3 alone -> vote_id=2.
REQ-030 mode=1 with button2 held 20 cycles -> no vote_valid; then mode=0, release, press button4 -> vote_id=3.
REQ-031 VOTE_LOCKOUT_EN, LOCKOUT_CYCLES=10: vote on button1, release, press button2 within 5 cycles and hold only until LOCKOUT ends -> no second vote; a fresh press after LOCKOUT -> vote_id=1.
REQ-032 Reset asserted 2 cycles into DEBOUNCE with button1 held, then deasserted -> outputs 0 during reset, exactly one vote_id=0 afterwards.
